i4001_rom: RTL

Instruction ROM and 4-bit I/O port for the MCS-4 system, sitting on the shared 4-bit data bus directly upstream of the i4004 CPU. It tracks the 8-phase instruction cycle from `sync`, captures the 12-bit fetch address during A1–A3, and returns the addressed byte as OPR (M1) and OPA (M2) when its chip ID matches. It also decodes SRC/WRR/RDR to drive a 4-bit output port and read a 4-bit input port. A side-band program port lets the PYNQ host load ROM contents.

---
 rtl/i4001_rom.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/i4001_rom.sv
// i4001_rom: MCS-4 instruction ROM (256 x 8) with a 4-bit I/O port.
//
// Follows the 8-phase bus cycle from sync. It captures the fetch address in
// A1-A3 and returns OPR/OPA in M1/M2 when the chip ID matches. It snoops
// SRC/WRR/RDR to run the I/O port. A host program port writes the array.
//
// Build option: define I4001_IO_EN to compile in the SRC/WRR/RDR decode,
// io_out latch and io_in sampling. Without it io_out is 0, io_in is ignored,
// and the chip drives the bus only in M1/M2 of a fetch.
//
// Parameters:
//   CHIP_ID    ROM chip number, matched against the A3 and SRC nibbles
//   INIT_FILE  optional hex image name
// Ports:
//   clk, rst           system clock (one bus phase per cycle), async active-high reset
//   sync               cycle marker from the CPU, high during X3
//   cm_rom             CPU ROM command line
//   dbus_in            resolved 4-bit data bus
//   dbus_out, dbus_oe  this chip's bus drive and its enable
//   io_in, io_out      I/O port pins and output latch
//   prog_we, prog_addr, prog_data  host write port ({OPR, OPA})
//   prog_busy          array read in flight; host writes are refused
module i4001_rom #(
  parameter logic [3:0] CHIP_ID   = 4'h0,
  parameter string      INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  input  logic       cm_rom,
  input  logic [3:0] dbus_in,
  output logic [3:0] dbus_out,
  output logic       dbus_oe,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic       prog_busy
);

  localparam int unsigned DW    = 4;
  localparam int unsigned BW    = 8;
  localparam int unsigned DEPTH = 256;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  phase_t          phase;
  logic [DW-1:0]   addr_lo;
  logic [DW-1:0]   addr_hi;
  logic            sel;
  logic [DW-1:0]   opr;
  logic [DW-1:0]   opa;
  logic            cm_m1;

  logic [BW-1:0]   mem [DEPTH];
  logic [BW-1:0]   rdata;

  logic            resync;
  logic            hit;
  logic            rd_en;
  logic            wr_en;

  // sync outside X3 abandons the cycle in flight
  assign resync = sync && (phase != PH_X3);
  assign hit    = (dbus_in == CHIP_ID) && cm_rom;
  assign rd_en  = (phase == PH_A3) && !resync && hit;
  // The read is issued on the same edge that raises prog_busy, so that edge
  // must refuse host writes too.
  assign wr_en  = prog_we && !prog_busy && !rd_en;

  // Array: host write port and synchronous fetch read; no reset on contents
  always_ff @(posedge clk) begin
    if (wr_en) mem[prog_addr] <= prog_data;
    if (rd_en) rdata <= mem[{addr_hi, addr_lo}];
  end

  // Phase tracking, address capture, chip select and instruction snoop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= PH_A1;
      addr_lo   <= '0;
      addr_hi   <= '0;
      sel       <= 1'b0;
      prog_busy <= 1'b0;
      opr       <= '0;
      opa       <= '0;
      cm_m1     <= 1'b0;
    end else if (resync) begin
      phase     <= PH_A1;
      sel       <= 1'b0;
      prog_busy <= 1'b0;
    end else begin
      phase <= sync ? PH_A1 : phase_t'(phase + 3'd1);
      case (phase)
        PH_A1: addr_lo <= dbus_in;
        PH_A2: addr_hi <= dbus_in;
        PH_A3: begin
          sel       <= rd_en;
          prog_busy <= rd_en;
        end
        PH_M1: begin
          opr   <= dbus_in;
          cm_m1 <= cm_rom;
        end
        PH_M2: begin
          opa       <= dbus_in;
          prog_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef I4001_IO_EN
  logic          src_sel;
  logic [DW-1:0] io_smp;
  logic          io_cmd;
  logic          wrr;
  logic          rdr;

  // IO group instruction: OPR = E fetched with cm_rom asserted in M1
  assign io_cmd = cm_m1 && (opr == 4'hE);
  assign wrr    = io_cmd && (opa == 4'h2) && src_sel;
  assign rdr    = io_cmd && (opa == 4'hA) && src_sel;

  // SRC select, io_in sampling and WRR output latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_sel <= 1'b0;
      io_smp  <= '0;
      io_out  <= '0;
    end else if (!resync) begin
      case (phase)
        PH_M2: io_smp <= io_in;
        PH_X2: begin
          if (cm_rom) src_sel <= (dbus_in == CHIP_ID);
          if (wrr)    io_out  <= dbus_in;
        end
        default: ;
      endcase
    end
  end
`else
  logic io_unused;

  assign io_out    = '0;
  assign io_unused = ^{io_in, opr, opa, cm_m1};
`endif

  // Bus drive: combinational from phase and registered state only
  always_comb begin
    dbus_out = '0;
    dbus_oe  = 1'b0;
    case (phase)
      PH_M1: begin
        if (sel) begin
          dbus_out = rdata[7:4];
          dbus_oe  = 1'b1;
        end
      end
      PH_M2: begin
        if (sel) begin
          dbus_out = rdata[3:0];
          dbus_oe  = 1'b1;
        end
      end
`ifdef I4001_IO_EN
      PH_X2: begin
        if (rdr) begin
          dbus_out = io_smp;
          dbus_oe  = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule
